hack_boot_loader: RTL and testbench
===================================

// Module: hack_boot_loader
// PURPOSE
//  Boot sequencer for the Hack CPU. Holds the CPU in reset, receives a program as a
//  byte stream (valid/ready), assembles 16-bit instruction words and writes them into
//  instruction ROM at addresses 0..N-1. It then checks a trailing checksum and releases
//  the CPU from reset. Sits between the host link (UART/debug) and the CPU/ROM pair.
// PARAMETERS
//  ADDR_W      15  ROM address width; max program = 2**ADDR_W words
//  TIMEOUT     0   max idle cycles between bytes once a frame has started; 0 = disabled
//  AUTO_START  1   1: enter LEN_HI when reset is released; 0: wait in IDLE for start
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-low (0 = reset)
//  start      in   1       1-cycle pulse; (re)starts a load from IDLE/DONE/ERR
//  rx_data    in   8       stream byte
//  rx_valid   in   1       rx_data valid
//  rx_ready   out  1       loader accepts byte this cycle
//  rom_we     out  1       ROM write strobe, 1 cycle per word
//  rom_addr   out  ADDR_W  ROM write address
//  rom_wdata  out  16      ROM write data
//  cpu_reset  out  1       active-high reset to CPU (CPU reset port is active-high)
//  busy       out  1       load in progress (LEN_HI..CSUM_LO)
//  done       out  1       load completed and checksum matched
//  err        out  1       sticky error: bad length, checksum mismatch or timeout
// BEHAVIOUR
//  - All outputs registered. Reset values: rx_ready=0, rom_we=0, rom_addr=0,
//    rom_wdata=0, cpu_reset=1, busy=0, done=0, err=0; state=IDLE.
//  - Frame format, big-endian: LEN[15:0] (word count N), then N words (hi, lo),
//    then CSUM[15:0] = sum of all N words mod 2**16.
//  - Byte accepted iff rx_valid && rx_ready. Byte is consumed only on acceptance.
//  - States: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CSUM_HI, CSUM_LO, DONE, ERR.
//    IDLE    : start -> LEN_HI. If AUTO_START=1, LEN_HI is entered on the first clk
//              after reset is released.
//    LEN_HI  : accept byte -> LEN_LO. No timeout here; the host may wait indefinitely.
//    LEN_LO  : accept byte; N==0 or N>2**ADDR_W -> ERR; else -> DAT_HI. Clears
//              rom_addr and the running sum.
//    DAT_HI  : accept byte -> DAT_LO.
//    DAT_LO  : accept byte -> WRITE.
//    WRITE   : rx_ready=0; rom_we=1 for exactly 1 cycle with assembled word.
//              rom_we is asserted the cycle after the lo byte is accepted.
//              sum += word; rom_addr increments after the write. If last word -> CSUM_HI,
//              else -> DAT_HI.
//    CSUM_HI : accept byte -> CSUM_LO.
//    CSUM_LO : accept byte; if it matches sum -> DONE, else -> ERR.
//    DONE    : done=1; cpu_reset=0 from the cycle after the final byte is accepted.
//    ERR     : err=1; cpu_reset stays 1; no ROM writes.
//  - rx_ready=1 in LEN_HI, LEN_LO, DAT_HI, DAT_LO, CSUM_HI and CSUM_LO; 0 elsewhere.
//  - cpu_reset=1 in every state except DONE. busy=1 in LEN_HI..CSUM_LO.
//  - start in DONE or ERR: clears done/err, sets cpu_reset=1, -> LEN_HI.
//  - start while busy: ignored.
//  - Timeout: counter clears on each accepted byte. It runs in LEN_LO..CSUM_LO,
//    including WRITE. When it reaches TIMEOUT -> ERR.
//  - rom_addr wraps never: the length check bounds the last address to 2**ADDR_W-1.
//  - Asynchronous reset mid-load: outputs take reset values immediately. ROM keeps the
//    partial contents; the next load starts at address 0.
// TESTING
//  - Bytes 00 03 30 39 EC 10 5B A0 77 E9 -> writes 0:3039, 1:EC10, 2:5BA0;
//    done=1; cpu_reset falls 1 cycle after byte E9.
//  - Same frame, last byte E8 -> err=1, done=0, cpu_reset=1; exactly 3 rom_we pulses.
//  - LEN=00 00 -> err=1 the cycle after the 2nd byte; 0 rom_we. With ADDR_W=4, LEN=00 11
//    (17) -> err=1.
//  - rx_valid held high continuously -> rx_ready=0 during each WRITE cycle; no byte lost
//    or duplicated; ROM contents match the first test.
//  - TIMEOUT=16: send 00, then idle -> err=1 exactly 16 cycles after acceptance.
//  - Assert reset during DAT_LO of word 1 -> all outputs at reset values at once.
//    Release reset and send the first-test frame -> identical result, writes start at 0.

Source files
------------

// File: rtl/hack_boot_loader.sv
// hack_boot_loader
// Boot sequencer for the Hack CPU. It holds the CPU in reset and receives a
// framed program over a valid/ready byte stream. Instruction words are written
// to ROM from address 0, the trailing checksum is verified, and on a match the
// CPU is released from reset.
//
// Frame (big-endian): LEN[15:0] = N, then N words as (hi, lo) byte pairs, then
// CSUM[15:0], which is the sum of all N words modulo 2**16.
//
// ADDR_W is limited to 16 bits or fewer because LEN is a 16-bit field.
`timescale 1ns/1ps

module hack_boot_loader #(
    parameter int ADDR_W     = 15,   // ROM address width
    parameter int TIMEOUT    = 0,    // idle cycles allowed between bytes, 0 = off
    parameter bit AUTO_START = 1'b1  // leave IDLE without a start pulse after reset
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DAT_HI,
        S_DAT_LO,
        S_WRITE,
        S_CSUM_HI,
        S_CSUM_LO,
        S_DONE,
        S_ERR
    } state_t;

    // The idle counter only has to reach TIMEOUT-1. The expiry is taken on the
    // edge that would otherwise step it to TIMEOUT.
    localparam int            TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam int unsigned   MAX_WORDS = 32'd1 << ADDR_W;

    state_t            state;
    logic [7:0]        hi_byte;    // high byte of LEN, data word or CSUM
    logic [15:0]       sum;        // running sum of the words written so far
    logic [ADDR_W-1:0] last_addr;  // N-1, the address of the final word
    logic [TW-1:0]     idle_cnt;   // cycles since the last accepted byte

    logic        accept;
    logic        timed;
    logic        timeout_hit;
    logic        len_bad;
    logic [15:0] pair;

    // A byte moves only when both sides agree in the same cycle.
    assign accept = rx_valid && rx_ready;

    // The byte on the bus together with the stored high byte forms a 16-bit field.
    assign pair = {hi_byte, rx_data};

    // The timeout window starts after LEN_HI, because the host may wait there
    // indefinitely before sending a frame.
    assign timed = state inside {S_LEN_LO, S_DAT_HI, S_DAT_LO, S_WRITE, S_CSUM_HI, S_CSUM_LO};

    assign timeout_hit = (TIMEOUT > 0) && timed && !accept && (idle_cnt == TO_LAST);

    // A zero length is rejected. A length beyond the ROM is also rejected, so
    // rom_addr can never wrap.
    assign len_bad = (pair == 16'd0) || (32'(pair) > MAX_WORDS);

    // Loader FSM. Every output is a register that is updated together with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rx_ready  <= 1'b0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= '0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            hi_byte   <= '0;
            sum       <= '0;
            last_addr <= '0;
            idle_cnt  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments. Every branch then
            // reads the values from before the edge, and a later assignment in this
            // block (such as the timeout override) cleanly replaces an earlier one.
            rom_we <= 1'b0;

            if (!timed || accept) begin
                idle_cnt <= '0;
            end else if (TIMEOUT > 0) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            unique case (state)
                S_IDLE: begin
                    if (start || AUTO_START) begin
                        state     <= S_LEN_HI;
                        rx_ready  <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        cpu_reset <= 1'b1;
                    end
                end

                S_LEN_HI: begin
                    if (accept) begin
                        hi_byte <= rx_data;
                        state   <= S_LEN_LO;
                    end
                end

                S_LEN_LO: begin
                    if (accept) begin
                        if (len_bad) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            busy     <= 1'b0;
                            rx_ready <= 1'b0;
                        end else begin
                            last_addr <= ADDR_W'(pair - 16'd1);
                            rom_addr  <= '0;
                            sum       <= '0;
                            state     <= S_DAT_HI;
                        end
                    end
                end

                S_DAT_HI: begin
                    if (accept) begin
                        hi_byte <= rx_data;
                        state   <= S_DAT_LO;
                    end
                end

                S_DAT_LO: begin
                    if (accept) begin
                        rom_wdata <= pair;
                        rom_we    <= 1'b1;
                        rx_ready  <= 1'b0;
                        state     <= S_WRITE;
                    end
                end

                // The word is presented to the ROM during this cycle. The address
                // advances afterwards, except after the last word.
                S_WRITE: begin
                    sum      <= sum + rom_wdata;
                    rx_ready <= 1'b1;
                    if (rom_addr == last_addr) begin
                        state <= S_CSUM_HI;
                    end else begin
                        rom_addr <= rom_addr + 1'b1;
                        state    <= S_DAT_HI;
                    end
                end

                S_CSUM_HI: begin
                    if (accept) begin
                        hi_byte <= rx_data;
                        state   <= S_CSUM_LO;
                    end
                end

                S_CSUM_LO: begin
                    if (accept) begin
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (pair == sum) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end

                S_DONE, S_ERR: begin
                    if (start) begin
                        state     <= S_LEN_HI;
                        rx_ready  <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        cpu_reset <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // A stalled link overrides whatever the current state was about to do.
            if (timeout_hit) begin
                state    <= S_ERR;
                err      <= 1'b1;
                busy     <= 1'b0;
                rx_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hack_boot_loader.sv
// Testbench for hack_boot_loader. It drives known and random frames. A
// frame-level model gives the expected ROM writes and the expected done/err
// outcome for each frame.
`timescale 1ns/1ps

module tb_hack_boot_loader;

    localparam int AW = 4;
    localparam int TO = 16;

    typedef struct {
        int          addr;
        logic [15:0] data;
        logic        rdy;   // rx_ready seen during the write cycle
    } wr_t;

    typedef logic [7:0] frame_t [$];

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          err;

    int   checks = 0;
    int   errors = 0;
    wr_t  wr_q[$];
    wr_t  exp_wr[$];
    bit   exp_ok;
    int   exp_used;
    logic pre_cpu_reset;
    logic [15:0] rom_shadow [2**AW];

    hack_boot_loader #(
        .ADDR_W    (AW),
        .TIMEOUT   (TO),
        .AUTO_START(1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rom_we   (rom_we),
        .rom_addr (rom_addr),
        .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // ROM-side monitor: record each write strobe on the falling edge.
    always @(negedge clk) begin
        wr_t w;
        if (reset === 1'b1 && rom_we === 1'b1) begin
            w.addr = int'(rom_addr);
            w.data = rom_wdata;
            w.rdy  = rx_ready;
            wr_q.push_back(w);
            rom_shadow[rom_addr] = rom_wdata;
        end
    end

    // Frame-level model: parse the byte list and predict the writes and the outcome.
    task automatic model(input frame_t fr);
        int          n;
        logic [15:0] s;
        wr_t         w;
        exp_wr.delete();
        n = int'({fr[0], fr[1]});
        if (n == 0 || n > (1 << AW)) begin
            exp_ok   = 1'b0;
            exp_used = 2;
            return;
        end
        s = 16'd0;
        for (int i = 0; i < n; i++) begin
            w.addr = i;
            w.data = {fr[2 + 2 * i], fr[3 + 2 * i]};
            w.rdy  = 1'b0;
            exp_wr.push_back(w);
            s = s + w.data;
        end
        exp_used = 4 + 2 * n;
        exp_ok   = ({fr[2 + 2 * n], fr[3 + 2 * n]} == s);
    endtask

    task automatic make_frame(input int n, input bit good, output frame_t fr);
        logic [15:0] s;
        logic [15:0] w;
        fr.delete();
        s = 16'd0;
        fr.push_back(8'(n >> 8));
        fr.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            s = s + w;
            fr.push_back(w[15:8]);
            fr.push_back(w[7:0]);
        end
        if (!good) s = s ^ (16'd1 << $urandom_range(0, 15));
        fr.push_back(s[15:8]);
        fr.push_back(s[7:0]);
    endtask

    task automatic known_frame(input logic [7:0] last, output frame_t fr);
        fr = '{8'h00, 8'h03, 8'h30, 8'h39, 8'hEC, 8'h10, 8'h5B, 8'hA0, 8'h77, last};
    endtask

    // Offer one byte from a falling edge. Return on the falling edge after it is taken.
    task automatic send_byte(input logic [7:0] b, output bit ok);
        rx_valid = 1'b1;
        rx_data  = b;
        ok       = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (rx_ready === 1'b1) begin
                pre_cpu_reset = cpu_reset;
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_wait: byte %h not accepted within 50 cycles", b);
            rx_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic pulse_start(input string name);
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({rx_ready, busy, done, err, cpu_reset} !== 5'b11001) begin
            errors++;
            $display("FAIL %s_start: ready/busy/done/err/cpu_reset=%b required 11001", name,
                     {rx_ready, busy, done, err, cpu_reset});
        end
    endtask

    task automatic compare_writes(input string name);
        checks++;
        if (wr_q.size() != exp_wr.size()) begin
            errors++;
            $display("FAIL %s_wcount: %0d rom writes, required %0d", name, wr_q.size(), exp_wr.size());
        end else begin
            foreach (exp_wr[i]) begin
                checks++;
                if (wr_q[i].addr != exp_wr[i].addr || wr_q[i].data !== exp_wr[i].data ||
                    wr_q[i].rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_write%0d: addr=%0d data=%h ready=%b required addr=%0d data=%h ready=0",
                             name, i, wr_q[i].addr, wr_q[i].data, wr_q[i].rdy,
                             exp_wr[i].addr, exp_wr[i].data);
                end
            end
        end
    endtask

    // Send a whole frame, then check the outcome on the cycle after the last byte.
    // start_at >= 0 pulses start before that byte, and the loader must ignore it.
    task automatic run_frame(input frame_t fr, input bit hold, input int start_at, input string name);
        bit ok;
        model(fr);
        wr_q.delete();
        for (int i = 0; i < exp_used; i++) begin
            if (i == start_at) begin
                rx_valid = 1'b0;
                start    = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if (i > 0 && !hold) begin
                rx_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            send_byte(fr[i], ok);
            if (!ok) return;
        end
        rx_valid = 1'b0;
        checks++;
        if (pre_cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL %s_cpu_reset_before: %b required 1", name, pre_cpu_reset);
        end
        checks++;
        if ({done, err, cpu_reset, busy, rx_ready} !== {exp_ok, !exp_ok, !exp_ok, 2'b00}) begin
            errors++;
            $display("FAIL %s_outcome: done/err/cpu_reset/busy/ready=%b required %b", name,
                     {done, err, cpu_reset, busy, rx_ready}, {exp_ok, !exp_ok, !exp_ok, 2'b00});
        end
        compare_writes(name);
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_ready, rom_we, rom_addr, rom_wdata, cpu_reset, busy, done, err} !== {2'b00, {AW{1'b0}}, 16'h0, 4'b1000}) begin
            errors++;
            $display("FAIL reset_values: ready=%b we=%b addr=%h wdata=%h cpu_reset=%b busy=%b done=%b err=%b",
                     rx_ready, rom_we, rom_addr, rom_wdata, cpu_reset, busy, done, err);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_ready: %b required 0", rx_ready);
        end
        @(negedge clk);
        checks++;
        if ({rx_ready, busy, cpu_reset} !== 3'b111) begin
            errors++;
            $display("FAIL autostart: ready/busy/cpu_reset=%b required 111", {rx_ready, busy, cpu_reset});
        end
    endtask

    task automatic test_known_frame();
        frame_t fr;
        known_frame(8'hE9, fr);
        run_frame(fr, 1'b0, -1, "known");
    endtask

    task automatic test_bad_csum();
        frame_t fr;
        pulse_start("bad_csum");
        known_frame(8'hE8, fr);
        run_frame(fr, 1'b0, -1, "bad_csum");
    endtask

    task automatic test_length_bounds();
        frame_t fr;
        pulse_start("len0");
        fr = '{8'h00, 8'h00};
        run_frame(fr, 1'b0, -1, "len0");
        pulse_start("len17");
        fr = '{8'h00, 8'h11};
        run_frame(fr, 1'b0, -1, "len17");
        pulse_start("len16");
        make_frame(16, 1'b1, fr);
        run_frame(fr, 1'b1, -1, "len16");
    endtask

    task automatic test_back_to_back();
        frame_t fr;
        pulse_start("b2b");
        known_frame(8'hE9, fr);
        run_frame(fr, 1'b1, -1, "b2b");
        checks++;
        if ({rom_shadow[0], rom_shadow[1], rom_shadow[2]} !== 48'h3039_EC10_5BA0) begin
            errors++;
            $display("FAIL b2b_rom: %h %h %h required 3039 EC10 5BA0", rom_shadow[0], rom_shadow[1], rom_shadow[2]);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int k;
        pulse_start("timeout");
        repeat (40) @(negedge clk);
        checks++;
        if ({err, rx_ready} !== 2'b01) begin
            errors++;
            $display("FAIL len_hi_no_timeout: err/ready=%b required 01", {err, rx_ready});
        end
        wr_q.delete();
        send_byte(8'h00, ok);
        rx_valid = 1'b0;
        k = 0;
        while (err !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != TO) begin
            errors++;
            $display("FAIL timeout_cycles: err after %0d cycles required %0d", k, TO);
        end
        checks++;
        if ({done, cpu_reset, busy, rx_ready} !== 4'b0100 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_state: done/cpu_reset/busy/ready=%b writes=%0d required 0100 and 0",
                     {done, cpu_reset, busy, rx_ready}, wr_q.size());
        end
    endtask

    task automatic test_start_while_busy();
        frame_t fr;
        pulse_start("busy_start");
        make_frame(3, 1'b1, fr);
        run_frame(fr, 1'b0, 3, "busy_start");
    endtask

    task automatic test_reset_midload();
        frame_t fr;
        bit ok;
        pulse_start("midload");
        known_frame(8'hE9, fr);
        for (int i = 0; i < 5; i++) send_byte(fr[i], ok);
        rx_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({rx_ready, rom_we, rom_addr, rom_wdata, cpu_reset, busy, done, err} !== {2'b00, {AW{1'b0}}, 16'h0, 4'b1000}) begin
            errors++;
            $display("FAIL midload_reset: ready=%b we=%b addr=%h wdata=%h cpu_reset=%b busy=%b done=%b err=%b",
                     rx_ready, rom_we, rom_addr, rom_wdata, cpu_reset, busy, done, err);
        end
        checks++;
        if (rom_shadow[0] !== 16'h3039) begin
            errors++;
            $display("FAIL midload_partial: rom[0]=%h required 3039", rom_shadow[0]);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_frame(fr, 1'b0, -1, "midload_reload");
    endtask

    task automatic test_random();
        frame_t fr;
        for (int t = 0; t < 12; t++) begin
            pulse_start("rand");
            make_frame($urandom_range(1, 6), ($urandom_range(0, 3) != 0), fr);
            run_frame(fr, 1'($urandom_range(0, 1)), -1, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_known_frame();
        test_bad_csum();
        test_length_bounds();
        test_back_to_back();
        test_timeout();
        test_start_while_busy();
        test_reset_midload();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
